// File: rtl/vx_cache_bypass_rsp_if.sv
// ---------------------------------------------------------------------------
// vx_cache_bypass_rsp_if
// Bundles the DRAM response channel (into the bypass block) and the per-lane
// core response channel (out of it).
//   slave  modport : used by vx_cache_bypass_rsp (consumes DRAM responses,
//                    produces core responses)
//   master modport : used by the DRAM side / core side environment
// Signals:
//   dram_rsp_valid/data/tag/ready : one full cache line plus routing tag
//   core_rsp_valid/data/tag/ready : NUM_REQS lanes, one word + core tag each
// ---------------------------------------------------------------------------
interface vx_cache_bypass_rsp_if #(
  parameter int NUM_REQS        = 4,
  parameter int CACHE_LINE_SIZE = 64,
  parameter int WORD_SIZE       = 4,
  parameter int CORE_TAG_WIDTH  = 3
);
  localparam int WORD_WIDTH     = 8 * WORD_SIZE;
  localparam int LINE_WIDTH     = 8 * CACHE_LINE_SIZE;
  localparam int WORD_SEL_BITS  = $clog2(CACHE_LINE_SIZE / WORD_SIZE);
  localparam int REQ_SEL_BITS   = $clog2(NUM_REQS);
  localparam int DRAM_TAG_WIDTH = CORE_TAG_WIDTH + WORD_SEL_BITS + REQ_SEL_BITS;

  logic                                        dram_rsp_valid;
  logic [LINE_WIDTH-1:0]                       dram_rsp_data;
  logic [DRAM_TAG_WIDTH-1:0]                   dram_rsp_tag;
  logic                                        dram_rsp_ready;

  logic [NUM_REQS-1:0]                         core_rsp_valid;
  logic [NUM_REQS-1:0][WORD_WIDTH-1:0]         core_rsp_data;
  logic [NUM_REQS-1:0][CORE_TAG_WIDTH-1:0]     core_rsp_tag;
  logic [NUM_REQS-1:0]                         core_rsp_ready;

  modport master (
    output dram_rsp_valid, dram_rsp_data, dram_rsp_tag,
    input  dram_rsp_ready,
    input  core_rsp_valid, core_rsp_data, core_rsp_tag,
    output core_rsp_ready
  );

  modport slave (
    input  dram_rsp_valid, dram_rsp_data, dram_rsp_tag,
    output dram_rsp_ready,
    output core_rsp_valid, core_rsp_data, core_rsp_tag,
    input  core_rsp_ready
  );
endinterface

// File: rtl/vx_cache_bypass_rsp.sv
// ---------------------------------------------------------------------------
// vx_cache_bypass_rsp
// Returns bypassed (non-cached) DRAM responses to the requesting core lane.
// Each DRAM response carries a full line; the tag tells which word of the
// line was asked for, which core lane asked, and the core's own tag. Only the
// selected word is kept, in a small circular response queue, and the head
// entry is presented to its lane until that lane accepts it.
// Ports:
//   clk       : clock, rising edge
//   reset     : asynchronous active-low reset (empties queue, clears count)
//   flush     : synchronous discard of all queued entries
//   bus       : vx_cache_bypass_rsp_if.slave (DRAM rsp in, core rsp out)
//   rsp_count : running count of responses delivered to the core (wraps)
// ---------------------------------------------------------------------------
module vx_cache_bypass_rsp #(
  parameter int NUM_REQS        = 4,
  parameter int CACHE_LINE_SIZE = 64,
  parameter int WORD_SIZE       = 4,
  parameter int CORE_TAG_WIDTH  = 3,
  parameter int RSPQ_SIZE       = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  vx_cache_bypass_rsp_if.slave      bus,
  output logic [31:0]               rsp_count
);
  localparam int WORD_WIDTH     = 8 * WORD_SIZE;
  localparam int WORDS_PER_LINE = CACHE_LINE_SIZE / WORD_SIZE;
  localparam int WORD_SEL_BITS  = $clog2(WORDS_PER_LINE);
  localparam int REQ_SEL_BITS   = $clog2(NUM_REQS);
  localparam int PTR_W          = $clog2(RSPQ_SIZE);
  localparam int CNT_W          = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RSPQ_SIZE);

  // Incoming response decode
  logic [WORDS_PER_LINE-1:0][WORD_WIDTH-1:0] line_words_s;
  logic [CORE_TAG_WIDTH-1:0]                 in_tag_s;
  logic [WORD_SEL_BITS-1:0]                  in_wsel_s;
  logic [REQ_SEL_BITS-1:0]                   in_lane_s;
  logic [WORD_WIDTH-1:0]                     in_word_s;

  // Queue storage (not reset: never observed while the queue is empty)
  logic [WORD_WIDTH-1:0]     word_mem_q [RSPQ_SIZE];
  logic [CORE_TAG_WIDTH-1:0] tag_mem_q  [RSPQ_SIZE];
  logic [REQ_SEL_BITS-1:0]   lane_mem_q [RSPQ_SIZE];

  // Queue control state
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic [31:0]      rsp_count_q, rsp_count_d;

  logic                      ready_s;
  logic                      enq_s;
  logic                      deq_s;
  logic                      not_empty_s;
  logic [REQ_SEL_BITS-1:0]   head_lane_s;
  logic [WORD_WIDTH-1:0]     head_word_s;
  logic [CORE_TAG_WIDTH-1:0] head_tag_s;
  logic [NUM_REQS-1:0]       core_valid_s;

  assign line_words_s = bus.dram_rsp_data;
  assign in_tag_s     = bus.dram_rsp_tag[CORE_TAG_WIDTH-1:0];
  assign in_wsel_s    = bus.dram_rsp_tag[CORE_TAG_WIDTH +: WORD_SEL_BITS];
  assign in_lane_s    = bus.dram_rsp_tag[CORE_TAG_WIDTH + WORD_SEL_BITS +: REQ_SEL_BITS];
  assign in_word_s    = line_words_s[in_wsel_s];

  assign not_empty_s  = (count_q != {CNT_W{1'b0}});
  assign head_lane_s  = lane_mem_q[rd_ptr_q];
  assign head_word_s  = word_mem_q[rd_ptr_q];
  assign head_tag_s   = tag_mem_q[rd_ptr_q];

  // A full queue refuses new entries even if the head leaves this cycle,
  // and a flush cycle accepts nothing because the entry would be discarded.
  assign ready_s = (count_q != FULL_CNT) && !flush;
  assign enq_s   = bus.dram_rsp_valid && ready_s;
  // Only the head entry's own lane can pop it; other ready bits are ignored.
  assign deq_s   = not_empty_s && bus.core_rsp_ready[head_lane_s] && !flush;

  assign bus.dram_rsp_ready = ready_s;
  assign rsp_count          = rsp_count_q;

  // Core response drive: head broadcast on all lanes, valid only on its lane
  always_comb begin
    core_valid_s = {NUM_REQS{1'b0}};
    if (not_empty_s) begin
      core_valid_s[head_lane_s] = 1'b1;
    end else begin
      core_valid_s = {NUM_REQS{1'b0}};
    end
    for (int l = 0; l < NUM_REQS; l++) begin
      if (not_empty_s) begin
        bus.core_rsp_data[l] = head_word_s;
        bus.core_rsp_tag[l]  = head_tag_s;
      end else begin
        bus.core_rsp_data[l] = {WORD_WIDTH{1'b0}};
        bus.core_rsp_tag[l]  = {CORE_TAG_WIDTH{1'b0}};
      end
    end
  end

  assign bus.core_rsp_valid = core_valid_s;

  // Queue storage write on accepted DRAM response
  always_ff @(posedge clk) begin
    if (enq_s) begin
      word_mem_q[wr_ptr_q] <= in_word_s;
      tag_mem_q[wr_ptr_q]  <= in_tag_s;
      lane_mem_q[wr_ptr_q] <= in_lane_s;
    end
  end

  // Next-state for pointers, occupancy and delivered count
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rsp_count_d = rsp_count_q;
    if (flush) begin
      wr_ptr_d    = {PTR_W{1'b0}};
      rd_ptr_d    = {PTR_W{1'b0}};
      count_d     = {CNT_W{1'b0}};
      rsp_count_d = rsp_count_q;
    end else begin
      if (enq_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (deq_s) begin
        rd_ptr_d    = rd_ptr_q + PTR_W'(1);
        rsp_count_d = rsp_count_q + 32'd1;
      end else begin
        rd_ptr_d    = rd_ptr_q;
        rsp_count_d = rsp_count_q;
      end
      case ({enq_s, deq_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      rsp_count_q <= 32'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rsp_count_q <= rsp_count_d;
    end
  end
endmodule

// File: doc/vx_cache_bypass_rsp.md
VX_CACHE_BYPASS_RSP -- requirements
Module: VX_cache_bypass_rsp

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4, number of core response lanes (power of 2).
REQ-002 SHALL have parameter CACHE_LINE_SIZE, default 64, DRAM line size in bytes.
REQ-003 SHALL have parameter WORD_SIZE, default 4, word size in bytes; WORD_WIDTH = 8*WORD_SIZE.
REQ-004 SHALL have parameter CORE_TAG_WIDTH, default 3, core tag width.
REQ-005 SHALL have parameter RSPQ_SIZE, default 4, response queue depth (power of 2, >=2).
REQ-006 SHALL derive the following widths:
- WORD_SEL_BITS = clog2(CACHE_LINE_SIZE/WORD_SIZE).
- REQ_SEL_BITS = clog2(NUM_REQS).
- DRAM_TAG_WIDTH = CORE_TAG_WIDTH+WORD_SEL_BITS+REQ_SEL_BITS.
REQ-007 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-008 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port flush, input, 1, synchronous queue discard.
REQ-010 SHALL have the DRAM response ports:
- dram_rsp_valid, input, 1.
- dram_rsp_data, input, 8*CACHE_LINE_SIZE.
- dram_rsp_tag, input, DRAM_TAG_WIDTH.
- dram_rsp_ready, output, 1.
REQ-011 SHALL have the core response ports:
- core_rsp_valid, output, NUM_REQS.
- core_rsp_data, output, NUM_REQS x WORD_WIDTH.
- core_rsp_tag, output, NUM_REQS x CORE_TAG_WIDTH.
- core_rsp_ready, input, NUM_REQS.
REQ-012 SHALL have port rsp_count, output, 32, count of responses delivered to the core.

Function
REQ-013 SHALL decode dram_rsp_tag as follows:
- [CORE_TAG_WIDTH-1:0] = core tag.
- next WORD_SEL_BITS = word offset within the line.
- top REQ_SEL_BITS = destination lane.
REQ-014 SHALL enqueue {selected word, core tag, lane} when dram_rsp_valid && dram_rsp_ready; only the selected word is stored. Word w is data[w*WORD_WIDTH +: WORD_WIDTH].
REQ-015 SHALL keep a circular queue with wr_ptr, rd_ptr (clog2(RSPQ_SIZE) bits, wrapping naturally) and count (0..RSPQ_SIZE).
REQ-016 SHALL drive dram_rsp_ready = (count != RSPQ_SIZE) && !flush.
- No enqueue while full, even if a dequeue occurs in the same cycle.
REQ-017 SHALL, when count != 0, drive the head entry combinationally:
- core_rsp_valid[head lane] = 1; all other valid bits 0.
- core_rsp_data and core_rsp_tag of every lane = head word and head tag.
REQ-018 SHALL dequeue when core_rsp_valid[lane] && core_rsp_ready[lane] for the head lane; ready bits of other lanes are ignored.
REQ-019 Minimum latency SHALL be 1 cycle: an entry accepted at edge N is visible on the core outputs after edge N, in cycle N+1.
REQ-020 SHALL update count by the following rules:
- Simultaneous enqueue and dequeue (count not full, not empty) leaves count unchanged.
- Enqueue alone: +1.
- Dequeue alone: -1.
REQ-021 Holding core_rsp_ready low SHALL hold the head valid, data and tag stable until accepted; entries SHALL be delivered in enqueue order.
REQ-022 When flush=1 at an edge, the block SHALL:
- set count, wr_ptr and rd_ptr to 0;
- discard any concurrent enqueue or dequeue;
- not increment rsp_count.
REQ-023 rsp_count SHALL increment by 1 on each dequeue and wrap modulo 2^32.
REQ-024 With empty queue, core_rsp_valid SHALL be 0 regardless of core_rsp_ready.

Reset
REQ-025 While reset=0, the block SHALL immediately (asynchronously) set:
- count, wr_ptr, rd_ptr and rsp_count to 0;
- core_rsp_valid to 0 and dram_rsp_ready to 1.
REQ-026 Reset asserted mid-operation SHALL discard all queued entries; the first response after release is the first one accepted after release.
REQ-027 Queue storage need not be reset; outputs SHALL not depend on it while count=0.

Verification
REQ-028 Single response, defaults:
- Stimulus: tag={lane 2, word 5, core tag 3'b101}, data word5=32'hDEADBEEF, core_rsp_ready all 1.
- Response: next cycle core_rsp_valid=4'b0100, data 32'hDEADBEEF, tag 3'b101; then valid=0 and rsp_count=1.
REQ-029 Fill and backpressure:
- Stimulus: 5 back-to-back responses with core_rsp_ready=0.
- Response: 4 accepted; dram_rsp_ready=0 after the 4th; 5th held.
- Then ready=1 on the head lane: entries drain in order; dram_rsp_ready returns 1 the cycle after the first dequeue.
REQ-030 Wrong-lane ready:
- Stimulus: head on lane 1, core_rsp_ready=4'b1101.
- Response: no dequeue and outputs stable; raising ready[1] dequeues.
REQ-031 Simultaneous enqueue and dequeue at count=2 for 10 cycles -> count stays 2, pointers wrap past 3 to 0, data order preserved.
REQ-032 Flush:
- Stimulus: flush with count=3 and dram_rsp_valid=1.
- Response: count=0 next cycle, concurrent entry dropped, core_rsp_valid=0, rsp_count unchanged.
REQ-033 Reset mid-operation:
- Stimulus: reset low asynchronously with count=2 and rsp_count=7.
- Response: core_rsp_valid=0 and rsp_count=0 without a clock edge.
